// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - BIN computed LSB first over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output OVF.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             bout_q;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;
    logic last;

    // One full-subtractor cell fed by the shift-register LSBs.
    assign a_bit   = sa[0];
    assign b_bit   = sb[0];
    assign d_bit   = a_bit ^ b_bit ^ br;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            d_q    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new START just like IDLE, so runs can be back-to-back.
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        sa    <= A;
                        sb    <= B;
                        br    <= BIN;
                        cnt   <= '0;
                        d_q   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    br  <= br_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    d_q <= {d_bit, d_q[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state  <= ST_DONE;
                        bout_q <= br_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // The final d_bit is the result MSB, so overflow resolves on the last RUN edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if ((state == ST_IDLE || state == ST_DONE) && START) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
        end else if (state == ST_RUN && last) begin
            ovf_q <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
        end
    end

    assign OVF = ovf_q;
`endif

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_DONE);
    assign D    = d_q;
    assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: vector table, random ops vs. arithmetic model, corner sequences.
module tb_serial_sub;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BOUT;
`ifdef SERIAL_SUB_OVF_EN
    logic             OVF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic cur_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return OVF;
`else
        return 1'b0;
`endif
    endfunction

    // Model: plain integer subtraction; borrow-out is the sign of the true difference.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bout, output logic ovf);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        d    = 8'(diff);
        bout = (diff < 0);
        ovf  = (a[7] != b[7]) && (d[7] != a[7]);
    endtask

    // Called at a negedge; returns at the negedge where DONE must be high.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input int rep,
                         output logic [7:0] dg, output logic bg, output logic og);
        int nb;
        START = 1'b1; A = a; B = b; BIN = bin;
        @(negedge CLK);
        START = 1'b0; A = 8'($urandom); B = 8'($urandom); BIN = 1'($urandom);
        nb = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (BUSY && !DONE) nb++;
            if (k == rep) begin
                START = 1'b1; A = 8'hFF; B = 8'h00;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        check("busy_cycles", 32'(nb), 32'(WIDTH));
        check("done_at_latency", 32'(DONE), 32'd1);
        check("busy_low_in_done", 32'(BUSY), 32'd0);
        dg = D; bg = BOUT; og = cur_ovf();
    endtask

    initial begin
        logic [7:0] dg, de;
        logic       bg, og, be, oe;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};

        RST_N = 1'b0; START = 1'b0; A = '0; B = '0; BIN = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_bout", 32'(BOUT), 32'd0);
        check("rst_ovf", 32'(cur_ovf()), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, -1, dg, bg, og);
            check($sformatf("vec%0d_d", i), 32'(dg), 32'(vecs[i].d));
            check($sformatf("vec%0d_bout", i), 32'(bg), 32'(vecs[i].bout));
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(og), 32'(vecs[i].ovf));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            model(ra, rb, rbin, de, be, oe);
            do_op(ra, rb, rbin, -1, dg, bg, og);
            check("rand_d", 32'(dg), 32'(de));
            check("rand_bout", 32'(bg), 32'(be));
`ifdef SERIAL_SUB_OVF_EN
            check("rand_ovf", 32'(og), 32'(oe));
`endif
        end

        // START re-pulsed 3 cycles into RUN must be ignored.
        do_op(8'h05, 8'h03, 1'b0, 3, dg, bg, og);
        check("repulse_d", 32'(dg), 32'h02);
        check("repulse_bout", 32'(bg), 32'd0);

        // START held high through DONE: DONE lasts one cycle and a new run starts.
        START = 1'b1; A = 8'h05; B = 8'h03; BIN = 1'b0;
        @(negedge CLK);
        A = 8'h10; B = 8'h01;
        repeat (WIDTH) @(negedge CLK);
        check("b2b_first_done", 32'(DONE), 32'd1);
        check("b2b_first_d", 32'(D), 32'h02);
        @(negedge CLK);
        check("b2b_done_one_cycle", 32'(DONE), 32'd0);
        check("b2b_restart_busy", 32'(BUSY), 32'd1);
        START = 1'b0;
        repeat (WIDTH) @(negedge CLK);
        check("b2b_second_done", 32'(DONE), 32'd1);
        check("b2b_second_d", 32'(D), 32'h0F);

        // Asynchronous reset mid-RUN; BOUT is 1 from the prior op so its clear is visible.
        do_op(8'h03, 8'h05, 1'b0, -1, dg, bg, og);
        check("pre_rst_bout", 32'(bg), 32'd1);
        START = 1'b1; A = 8'h00; B = 8'h01; BIN = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre_rst_d_nonzero", 32'(D != 8'h00), 32'd1);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_busy", 32'(BUSY), 32'd0);
        check("async_rst_done", 32'(DONE), 32'd0);
        check("async_rst_d", 32'(D), 32'd0);
        check("async_rst_bout", 32'(BOUT), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            repeat (2 * WIDTH) begin
                @(negedge CLK);
                if (DONE || BUSY) seen_done++;
            end
            check("aborted_no_done", 32'(seen_done), 32'd0);
        end
        do_op(8'h09, 8'h04, 1'b0, -1, dg, bg, og);
        check("post_rst_d", 32'(dg), 32'h05);
        check("post_rst_bout", 32'(bg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
